// File: rtl/link_tx.sv
// link_tx: serializes the local {ready, hit, cords} handshake word onto an
// idle-high wire. A frame goes out on reset, on any change of the word, and
// periodically so the far-end receiver recovers after its own reset.
// Line order, LSB first: start(0), cords[0..7], hit, ready, even parity,
// stop(1), followed by a two-bit idle gap.
module link_tx #(
  parameter int CLKS_PER_BIT   = 868,
  parameter int REFRESH_PERIOD = 65536
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ready_in,
  input  logic       hit_in,
  input  logic [7:0] cords_in,
  output logic       tx,
  output logic       busy,
  output logic       frame_done
);
  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int RW = $clog2(REFRESH_PERIOD);
  localparam logic [TW-1:0] BIT_LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [RW-1:0] REF_LAST = RW'(REFRESH_PERIOD - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, GAP} state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [3:0]    idx_q, idx_d;
  logic [10:0]   sh_q, sh_d;      // {parity, payload}; bit 0 is on the line
  logic [9:0]    last_q, last_d;  // snapshot of the most recent frame
  logic [RW-1:0] ref_q, ref_d;
  logic          pend_q, pend_d;
  logic          force_q, force_d;
  logic          tx_q, tx_d;
  logic          busy_q, busy_d;
  logic          fd_q, fd_d;

  logic [9:0] payload;
  logic       bit_end, ref_hit, trigger, start;

  assign payload = {ready_in, hit_in, cords_in};
  assign bit_end = (tmr_q == BIT_LAST);
  // Comparing the live count lets the refresh frame start exactly one
  // period after the previous start rather than one cycle later.
  assign ref_hit = (ref_q == REF_LAST);
  assign trigger = force_q | (payload != last_q) | pend_q | ref_hit;
  assign start   = (state_q == IDLE) && trigger;

  assign tx         = tx_q;
  assign busy       = busy_q;
  assign frame_done = fd_q;

  // State register, timers, snapshots and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      tmr_q   <= '0;
      idx_q   <= '0;
      sh_q    <= '0;
      last_q  <= '0;
      ref_q   <= '0;
      pend_q  <= 1'b0;
      force_q <= 1'b1;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      fd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      last_q  <= last_d;
      ref_q   <= ref_d;
      pend_q  <= pend_d;
      force_q <= force_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      fd_q    <= fd_d;
    end
  end

  // Next-state: frame sequencing, bit timing and refresh bookkeeping.
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    idx_d   = idx_q;
    sh_d    = sh_q;
    last_d  = last_q;
    ref_d   = ref_q;
    pend_d  = pend_q;
    force_d = force_q;

    if (state_q != IDLE) tmr_d = bit_end ? '0 : tmr_q + 1'b1;

    // Refresh timer restarts on every frame start and holds once pending.
    if (start) begin
      ref_d  = '0;
      pend_d = 1'b0;
    end else if (!pend_q) begin
      if (ref_hit) pend_d = 1'b1;
      else         ref_d  = ref_q + 1'b1;
    end

    unique case (state_q)
      IDLE: if (trigger) begin
        state_d = START;
        tmr_d   = '0;
        idx_d   = '0;
        sh_d    = {^payload, payload};
        last_d  = payload;
        force_d = 1'b0;
      end
      START: if (bit_end) begin
        state_d = DATA;
        idx_d   = '0;
      end
      DATA: if (bit_end) begin
        sh_d = {1'b1, sh_q[10:1]};
        if (idx_q == 4'd9) begin
          state_d = PARITY;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + 4'd1;
        end
      end
      PARITY: if (bit_end) state_d = STOP;
      STOP: if (bit_end) begin
        state_d = GAP;
        idx_d   = '0;
      end
      GAP: if (bit_end) begin
        if (idx_q == 4'd1) state_d = IDLE;
        else               idx_d   = idx_q + 4'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they register in step with it.
  always_comb begin
    busy_d = (state_d != IDLE);
    fd_d   = (state_d == GAP) && (idx_d == 4'd1) && (tmr_d == BIT_LAST);
    unique case (state_d)
      START:        tx_d = 1'b0;
      DATA, PARITY: tx_d = sh_d[0];
      default:      tx_d = 1'b1;
    endcase
  end
endmodule
